// File: rtl/lmmi_initiator.sv
// Single-outstanding LMMI master: one valid/ready command in, one LMMI transaction out, one response back.
// Optional timeout counter and error response are built only when LMMI_INIT_TIMEOUT_EN is defined.
module lmmi_initiator #(
    parameter int unsigned OFFSET_W    = 18,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                lmmi_clk_i,
    input  logic                reset_n_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_wr_rdn_i,
    input  logic [OFFSET_W-1:0] cmd_offset_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                lmmi_request_o,
    output logic                lmmi_wr_rdn_o,
    output logic [OFFSET_W-1:0] lmmi_offset_o,
    output logic [DATA_W-1:0]   lmmi_wdata_o,
    input  logic [DATA_W-1:0]   lmmi_rdata_i,
    input  logic                lmmi_rdata_valid_i,
    input  logic                lmmi_ready_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  wr_rdn_q, wr_rdn_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  to_hit;

`ifdef LMMI_INIT_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // cnt_q counts cycles already spent in the state, so the last allowed cycle is TIMEOUT_CYC-1.
    assign to_hit = (cnt_q == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        if ((state_q == REQ || state_q == WAIT_RD) && state_d == state_q)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wr_rdn_d    = wr_rdn_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    wr_rdn_d = cmd_wr_rdn_i;
                    offset_d = cmd_offset_i;
                    wdata_d  = cmd_wdata_i;
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // A real completion in the timeout cycle takes priority over the error.
                if (lmmi_ready_i) begin
                    req_d = 1'b0;
                    if (wr_rdn_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else if (lmmi_rdata_valid_i) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = lmmi_rdata_i;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (to_hit) begin
                    req_d       = 1'b0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            WAIT_RD: begin
                if (lmmi_rdata_valid_i) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lmmi_rdata_i;
                    rsp_err_d   = 1'b0;
                end else if (to_hit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            wr_rdn_q    <= 1'b0;
            offset_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wr_rdn_q    <= wr_rdn_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o    = (state_q == IDLE);
    assign lmmi_request_o = req_q;
    assign lmmi_wr_rdn_o  = wr_rdn_q;
    assign lmmi_offset_o  = offset_q;
    assign lmmi_wdata_o   = wdata_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_lmmi_initiator.sv
// Scoreboard bench for lmmi_initiator: expected LMMI bus beats and responses are queued at issue
// time and compared by a monitor when the DUT presents them.
module tb_lmmi_initiator;
    localparam int OW = 18;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_wr = 1'b0;
    logic [OW-1:0] cmd_off = '0;
    logic [DW-1:0] cmd_wd = '0;
    logic          cmd_ready_o, rsp_valid_o, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          lmmi_request_o, lmmi_wr_rdn_o;
    logic [OW-1:0] lmmi_offset_o;
    logic [DW-1:0] lmmi_wdata_o;
    logic [DW-1:0] lmmi_rdata = '0;
    logic          lmmi_rdata_valid = 1'b0, lmmi_ready = 1'b0;

    always #5 clk = ~clk;

    lmmi_initiator #(.OFFSET_W(OW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .lmmi_clk_i(clk), .reset_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_wr_rdn_i(cmd_wr),
        .cmd_offset_i(cmd_off), .cmd_wdata_i(cmd_wd),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .lmmi_request_o(lmmi_request_o), .lmmi_wr_rdn_o(lmmi_wr_rdn_o),
        .lmmi_offset_o(lmmi_offset_o), .lmmi_wdata_o(lmmi_wdata_o),
        .lmmi_rdata_i(lmmi_rdata), .lmmi_rdata_valid_i(lmmi_rdata_valid), .lmmi_ready_i(lmmi_ready)
    );

    int n_chk = 0, n_pass = 0;
    int rsp_cnt = 0, req_cyc = 0, overlap = 0;
    logic [DW-1:0]  exp_rdata[$];
    logic           exp_err[$];
    logic [OW+DW:0] exp_bus[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic wr, input logic [OW-1:0] off, input logic [DW-1:0] wd);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_off = off; cmd_wd = wd;
        exp_bus.push_back({wr, off, wd});
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic exp_rsp(input logic [DW-1:0] rd, input logic err);
        exp_rdata.push_back(rd);
        exp_err.push_back(err);
    endtask

    // Monitor: bus beats on request&ready, responses on rsp_valid.
    always begin
        logic [OW+DW:0] b;
        @(posedge clk); #2;
        if (rst_n) begin
            if (lmmi_request_o) req_cyc++;
            if (lmmi_request_o && rsp_valid_o) overlap++;
            if (lmmi_request_o && lmmi_ready) begin
                chk("bus_q_nonempty", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) begin
                    b = exp_bus.pop_front();
                    chk("bus_beat", {lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o}, b);
                end
            end
            if (rsp_valid_o) begin
                rsp_cnt++;
                chk("rsp_q_nonempty", exp_rdata.size() != 0, 1);
                if (exp_rdata.size() != 0) begin
                    chk("rsp_rdata", rsp_rdata_o, exp_rdata.pop_front());
                    chk("rsp_err", rsp_err_o, exp_err.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_req, base_rsp, guard;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_bus", {lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o}, 0);
        chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
        rst_n = 1'b1;
        cyc();

        // Write, ready tied high
        lmmi_ready = 1'b1;
        issue(1'b1, 18'h00010, 32'hA5A5_0001);
        exp_rsp(32'h0, 1'b0);
        chk("t1_req", lmmi_request_o, 1);
        chk("t1_busy", cmd_ready_o, 0);
        cyc();
        chk("t1_req_drop", lmmi_request_o, 0);
        chk("t1_rsp", rsp_valid_o, 1);
        cyc();
        chk("t1_rsp_pulse", rsp_valid_o, 0);
        chk("t1_ready", cmd_ready_o, 1);
        lmmi_ready = 1'b0;

        // Read, ready after 4 request cycles, data two cycles later
        issue(1'b0, 18'h20040, 32'h0);
        exp_rsp(32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_hold", {lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o}, {1'b1, 1'b0, 18'h20040});
            if (i == 3) lmmi_ready = 1'b1;
            cyc();
        end
        lmmi_ready = 1'b0;
        chk("t2_wait_req", lmmi_request_o, 0);
        cyc();
        lmmi_rdata_valid = 1'b1; lmmi_rdata = 32'hDEAD_BEEF;
        cyc();
        lmmi_rdata_valid = 1'b0; lmmi_rdata = '0;
        chk("t2_rsp", rsp_valid_o, 1);
        cyc();
        chk("t2_pulse", rsp_valid_o, 0);
        chk("t2_hold", rsp_rdata_o, 32'hDEAD_BEEF);

        // Zero-wait read
        lmmi_ready = 1'b1; lmmi_rdata_valid = 1'b1; lmmi_rdata = 32'h1234_5678;
        issue(1'b0, 18'h3FFFF, 32'h0);
        exp_rsp(32'h1234_5678, 1'b0);
        cyc();
        lmmi_ready = 1'b0; lmmi_rdata_valid = 1'b0; lmmi_rdata = '0;
        chk("t3_rsp", rsp_valid_o, 1);
        chk("t3_req", lmmi_request_o, 0);
        cyc();

        // Back-to-back writes with cmd_valid held
        lmmi_ready = 1'b1;
        base_req = req_cyc; base_rsp = rsp_cnt;
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            while (!cmd_ready_o && guard < 10) begin cyc(); guard++; end
            chk("t4_ready_wait", guard < 10, 1);
            cmd_wr = 1'b1; cmd_off = 18'h100 + 18'(k); cmd_wd = 32'hB000_0000 + 32'(k);
            exp_bus.push_back({1'b1, cmd_off, cmd_wd});
            exp_rsp(32'h0, 1'b0);
            cyc();
        end
        cmd_valid = 1'b0;
        repeat (4) cyc();
        chk("t4_reqs", req_cyc - base_req, 4);
        chk("t4_rsps", rsp_cnt - base_rsp, 4);
        chk("t4_overlap", overlap, 0);

        // Spurious rdata_valid / ready in IDLE
        base_rsp = rsp_cnt;
        lmmi_rdata_valid = 1'b1; lmmi_rdata = 32'hBAD0_BAD0;
        repeat (3) cyc();
        lmmi_rdata_valid = 1'b0; lmmi_ready = 1'b0;
        cyc();
        chk("spur_rsp", rsp_cnt, base_rsp);
        chk("spur_idle", cmd_ready_o, 1);

        // Ready never comes
        issue(1'b1, 18'h00ABC, 32'hCAFE_0005);
`ifdef LMMI_INIT_TIMEOUT_EN
        exp_rsp(32'h0, 1'b1);
        for (int i = 0; i < TO; i++) begin
            chk("t5_req_hold", lmmi_request_o, 1);
            cyc();
        end
        chk("t5_req_drop", lmmi_request_o, 0);
        chk("t5_rsp", {rsp_valid_o, rsp_err_o}, 2'b11);
        exp_bus.delete();
        cyc();
`else
        base_rsp = rsp_cnt;
        repeat (20) cyc();
        chk("t5_wait_req", lmmi_request_o, 1);
        chk("t5_no_rsp", rsp_cnt, base_rsp);
        exp_rsp(32'h0, 1'b0);
        lmmi_ready = 1'b1;
        cyc();
        lmmi_ready = 1'b0;
        chk("t5_late_rsp", rsp_valid_o, 1);
        cyc();
`endif
        lmmi_ready = 1'b1;
        issue(1'b1, 18'h00011, 32'h0000_0011);
        exp_rsp(32'h0, 1'b0);
        cyc();
        chk("t5_next_rsp", rsp_valid_o, 1);
        cyc();
        lmmi_ready = 1'b0;

        // Reset while in REQ
        base_rsp = rsp_cnt;
        issue(1'b1, 18'h00155, 32'h0000_0006);
        chk("t6_req", lmmi_request_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_drop", lmmi_request_o, 0);
        chk("t6_ready_rst", cmd_ready_o, 1);
        exp_bus.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) cyc();
        chk("t6_ready", cmd_ready_o, 1);
        chk("t6_no_rsp", rsp_cnt, base_rsp);
        chk("t6_rsp_q_empty", exp_rdata.size(), 0);
        chk("end_bus_q_empty", exp_bus.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lmmi_initiator.md
Name: lmmi_initiator

Overview:
- Single-outstanding LMMI master. It converts a simple valid/ready command stream from the main FSM into LMMI request/ready/rdata_valid transactions.
- It drives the LMMI responder ports of the CRE block (18-bit offset, 32-bit data) or of the config LMMI (8-bit offset, 8-bit data), with widths set by parameter.
- It returns one response per command: read data on reads, plus an error flag on timeout.

Parameters:
- OFFSET_W, 18, width of LMMI offset bus.
- DATA_W, 32, width of LMMI wdata/rdata bus.
- TIMEOUT_CYC, 255, max cycles waited for lmmi_ready_i, or for lmmi_rdata_valid_i after read acceptance; legal range 1..65535.

Ports:
- lmmi_clk_i  input  1  block clock; all logic on rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  block can accept a command.
- cmd_wr_rdn_i  input  1  1 = write, 0 = read.
- cmd_offset_i  input  OFFSET_W  target offset.
- cmd_wdata_i  input  DATA_W  write data.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_rdata_o  output  DATA_W  read data; 0 for writes and errors.
- rsp_err_o  output  1  response is a timeout; qualified by rsp_valid_o.
- lmmi_request_o  output  1  LMMI request.
- lmmi_wr_rdn_o  output  1  LMMI write/read_n.
- lmmi_offset_o  output  OFFSET_W  LMMI offset.
- lmmi_wdata_o  output  DATA_W  LMMI write data.
- lmmi_rdata_i  input  DATA_W  LMMI read data.
- lmmi_rdata_valid_i  input  1  LMMI read data valid.
- lmmi_ready_i  input  1  LMMI request accepted.

Behaviour:
- Reset values (asynchronous on reset_n_i low):
  - FSM = IDLE; counter = 0.
  - cmd_ready_o = 1.
  - lmmi_request_o = 0; lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o = 0.
  - rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0.
- All outputs are registered. cmd_ready_o = (state == IDLE).
- State IDLE:
  - On cmd_valid_i & cmd_ready_o (cycle N), register wr_rdn/offset/wdata onto the LMMI buses and move to REQ.
  - lmmi_request_o = 1 from cycle N+1.
- State REQ:
  - Hold request and all LMMI buses stable until lmmi_ready_i = 1.
  - On request & ready, deassert request the next cycle.
  - Write: go to RESP.
  - Read: go to WAIT_RD. Exception: if lmmi_rdata_valid_i is also high in the same cycle, capture lmmi_rdata_i and go to RESP (zero-wait read).
- State WAIT_RD:
  - request = 0.
  - On lmmi_rdata_valid_i, capture lmmi_rdata_i and go to RESP.
- State RESP:
  - rsp_valid_o = 1 for exactly one cycle; rsp_rdata_o = captured data (0 for writes); rsp_err_o = 0.
  - Next state is IDLE, so the next command can be accepted one cycle after RESP.
- Minimum latency:
  - Write: command accepted at N, ready at N+1, rsp_valid_o at N+2, cmd_ready_o at N+3.
  - Read with rdata_valid at N+2: rsp_valid_o at N+3.
- rsp_rdata_o holds its value until the next response.
- lmmi_rdata_valid_i outside REQ/WAIT_RD (spurious or late) is ignored, with no state change.
- lmmi_ready_i outside REQ is ignored.
- Timeout counter:
  - Clears on entry to REQ and on entry to WAIT_RD; increments each cycle in those states.
  - On reaching TIMEOUT_CYC: deassert request, go to RESP with rsp_err_o = 1 and rsp_rdata_o = 0.
  - If ready (or rdata_valid) arrives in the same cycle the count hits TIMEOUT_CYC, the real completion wins and no error is reported.
- Reset mid-transaction: request drops immediately (asynchronous), no response is issued, and the command is lost.
- cmd_* inputs are not sampled outside IDLE. No command queuing.

Optional Feature:
- Macro: LMMI_INIT_TIMEOUT_EN.
- Defined: timeout counter and error path exist as described above.
- Undefined: no counter; REQ and WAIT_RD wait indefinitely; rsp_err_o is tied to 0; TIMEOUT_CYC is unused.

Test Plan:
- Write with lmmi_ready_i tied 1, offset 18'h00010, wdata 32'hA5A5_0001 -> request high exactly 1 cycle with those values; rsp_valid_o 2 cycles after acceptance, rsp_err_o = 0, rsp_rdata_o = 0.
- Read with ready delayed 3 cycles and rdata_valid 2 cycles after acceptance, rdata 32'hDEAD_BEEF -> request held stable 4 cycles; single rsp_valid_o pulse with rsp_rdata_o = 32'hDEAD_BEEF.
- Zero-wait read: ready and rdata_valid in the same cycle, data 32'h1234_5678 -> no WAIT_RD; response next cycle with 32'h1234_5678.
- Timeout (macro defined, TIMEOUT_CYC = 8), ready never asserted -> request drops after 8 cycles; rsp_valid_o with rsp_err_o = 1 and rdata = 0; next command accepted.
- Back-to-back: 4 writes with cmd_valid_i held high -> exactly 4 LMMI requests, 4 responses, no overlap. Assert spurious rdata_valid in IDLE -> no response.
- reset_n_i low during REQ -> lmmi_request_o = 0 asynchronously, rsp_valid_o never pulses, cmd_ready_o = 1 after release.
